// File: rtl/lut_layer_sched_if.sv
// lut_layer_sched_if: config, input-vector, result and status signals of one LUT layer evaluator.
// The stats outputs exist only when LUT_LAYER_SCHED_STATS_EN is defined.
interface lut_layer_sched_if #(
    parameter int NUM_NEURONS = 64,
    parameter int IN_BITS     = 8
);
    localparam int IDX_W = $clog2(NUM_NEURONS);

    logic                           cfg_we;
    logic [IDX_W-1:0]               cfg_neuron;
    logic [IN_BITS-1:0]             cfg_addr;
    logic                           cfg_data;
    logic                           cfg_ready;
    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_NEURONS*IN_BITS-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_NEURONS-1:0]         out_data;
    logic                           busy;
`ifdef LUT_LAYER_SCHED_STATS_EN
    logic [31:0]                    stat_frames;
    logic [31:0]                    stat_stall;
`endif

    modport master (
        output cfg_we, cfg_neuron, cfg_addr, cfg_data, in_valid, in_data, out_ready,
`ifdef LUT_LAYER_SCHED_STATS_EN
        input  stat_frames, stat_stall,
`endif
        input  cfg_ready, in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  cfg_we, cfg_neuron, cfg_addr, cfg_data, in_valid, in_data, out_ready,
`ifdef LUT_LAYER_SCHED_STATS_EN
        output stat_frames, stat_stall,
`endif
        output cfg_ready, in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/lut_layer_sched.sv
// lut_layer_sched: evaluates a layer of writable IN_BITS-input truth tables, one neuron per clock.
// Optional frame/stall counters are enabled by defining LUT_LAYER_SCHED_STATS_EN.
module lut_layer_sched #(
    parameter int NUM_NEURONS = 64,
    parameter int IN_BITS     = 8
) (
    input logic              clk,
    input logic              rst_n,
    lut_layer_sched_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam int DEPTH = NUM_NEURONS << IN_BITS;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d, rd_idx_q;
    logic [NUM_NEURONS*IN_BITS-1:0] in_q, in_d;
    logic [NUM_NEURONS-1:0]         out_q, out_d;
    logic                           rd_q, rd_v_q;
    logic                           mem [DEPTH];
    logic [IN_BITS-1:0]             addr;

    assign addr          = in_q[idx_q*IN_BITS +: IN_BITS];
    assign bus.cfg_ready = state_q == IDLE;
    assign bus.in_ready  = rst_n && state_q == IDLE && !bus.cfg_we;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_data  = out_q;
    assign bus.busy      = state_q == RUN || state_q == DRAIN;

    // Table memory: config write only while idle, registered read of the current neuron's entry.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && state_q == IDLE) mem[{bus.cfg_neuron, bus.cfg_addr}] <= bus.cfg_data;
        rd_q <= mem[{idx_q, addr}];
    end

    // FSM state register; reset aborts any evaluation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers; rd_v_q/rd_idx_q tag which result bit the read data belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            in_q     <= '0;
            out_q    <= '0;
            rd_v_q   <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            idx_q    <= idx_d;
            in_q     <= in_d;
            out_q    <= out_d;
            rd_v_q   <= state_q == RUN;
            rd_idx_q <= idx_q;
        end
    end

    // Next-state logic: capture on accept, step idx without wrapping, drain the last read, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        in_d    = in_q;
        out_d   = out_q;
        if (rd_v_q) out_d[rd_idx_q] = rd_q;
        case (state_q)
            IDLE: if (bus.in_valid && bus.in_ready) begin
                in_d    = bus.in_data;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                idx_d   = idx_q == LAST ? idx_q : idx_q + 1'b1;
                state_d = idx_q == LAST ? DRAIN : RUN;
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

`ifdef LUT_LAYER_SCHED_STATS_EN
    logic [31:0] frames_q, stall_q;

    // Saturating counters of output handshakes and backpressured DONE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_q <= '0;
            stall_q  <= '0;
        end else begin
            if (state_q == DONE && bus.out_ready && frames_q != '1) frames_q <= frames_q + 1'b1;
            if (state_q == DONE && !bus.out_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.stat_frames = frames_q;
    assign bus.stat_stall  = stall_q;
`endif
endmodule

// File: tb/tb_lut_layer_sched.sv
// tb_lut_layer_sched: directed and randomized checks of lut_layer_sched against a truth-table model.
module tb_lut_layer_sched;
    localparam int N = 4;
    localparam int B = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   tbl [N][256];

    lut_layer_sched_if #(.NUM_NEURONS(N), .IN_BITS(B)) bus ();
    lut_layer_sched #(.NUM_NEURONS(N), .IN_BITS(B)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] model(input logic [N*B-1:0] v);
        logic [N-1:0] r;
        for (int n = 0; n < N; n++) r[n] = tbl[n][v[n*B +: B]];
        return r;
    endfunction

    task automatic cfg(input int n, input int a, input bit d);
        bus.cfg_we     = 1'b1;
        bus.cfg_neuron = 2'(n);
        bus.cfg_addr   = 8'(a);
        bus.cfg_data   = d;
        step();
        bus.cfg_we = 1'b0;
        tbl[n][a]  = d;
    endtask

    // Sends one vector, waits for the result, optionally stalls, then completes the handshake.
    // With poke set, a config write is attempted in the first RUN cycle and must be ignored.
    task automatic run(input logic [N*B-1:0] v, input int stall, input bit poke,
                       output logic [N-1:0] res, output int lat);
        int c;
        c = 0;
        while (!bus.in_ready && c < 50) begin step(); c++; end
        check("in_ready_wait", 32'(bus.in_ready), 1);
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        c = 0;
        while (!bus.out_valid && c < 50) begin
            if (poke && c == 0) begin
                check("cfg_ready_run", 32'(bus.cfg_ready), 0);
                bus.cfg_we     = 1'b1;
                bus.cfg_neuron = 2'd3;
                bus.cfg_addr   = 8'h40;
                bus.cfg_data   = 1'b0;
            end
            step();
            bus.cfg_we = 1'b0;
            c++;
        end
        lat = c;
        check("out_valid_wait", 32'(bus.out_valid), 1);
        res = bus.out_data;
        for (int i = 0; i < stall; i++) begin
            step();
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_data", 32'(bus.out_data), 32'(res));
            check("hold_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("out_valid_drop", 32'(bus.out_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]   res, first;
        logic [N*B-1:0] v;
        int             lat;
        bus.cfg_we = 0; bus.cfg_neuron = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        #12 rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_busy", 32'(bus.busy), 0);
        step();
        for (int n = 0; n < N; n++)
            for (int a = 0; a < 256; a++) cfg(n, a, a == 16 * (n + 1));

        run(32'h40302010, 0, 1'b0, first, lat);
        check("all_ones", 32'(first), 32'hF);
        check("latency", 32'(lat), N + 1);
        run(32'h41302110, 0, 1'b0, res, lat);
        check("pattern_0101", 32'(res), 32'h5);

        bus.cfg_we = 1'b1; bus.cfg_neuron = 2'd1; bus.cfg_addr = 8'h21; bus.cfg_data = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 32'h41302110;
        #1;
        check("cfg_wins_in_ready", 32'(bus.in_ready), 0);
        step();
        bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
        tbl[1][8'h21] = 1'b1;
        check("cfg_wins_not_busy", 32'(bus.busy), 0);
        run(32'h41302110, 0, 1'b0, res, lat);
        check("cfg_write_landed", 32'(res), 32'(model(32'h41302110)));

        run(32'h41302110, 0, 1'b1, res, lat);
        run(32'h40302010, 0, 1'b0, res, lat);
        check("run_write_ignored", 32'(res), 32'(model(32'h40302010)));

        run(32'h40302010, 10, 1'b0, res, lat);
        step();
        check("in_ready_after", 32'(bus.in_ready), 1);

        bus.in_data = 32'h40302010; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        check("mid_run_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_cfg_ready", 32'(bus.cfg_ready), 1);
        #3 rst_n = 1'b1;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 1);
        run(32'h40302010, 0, 1'b0, res, lat);
        check("tables_retained", 32'(res), 32'(first));

        for (int it = 0; it < 30; it++) begin
            v = N*B'($urandom);
            for (int n = 0; n < N; n++)
                if ($urandom_range(0, 1) == 1) cfg(n, int'(v[n*B +: B]), 1'($urandom_range(0, 1)));
            run(v, $urandom_range(0, 3), 1'b0, res, lat);
            check("rand_result", 32'(res), 32'(model(v)));
            check("rand_latency", 32'(lat), N + 1);
        end

`ifdef LUT_LAYER_SCHED_STATS_EN
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check("stats_reset", bus.stat_frames, 0);
        run(32'h40302010, 0, 1'b0, res, lat);
        run(32'h40302010, 5, 1'b0, res, lat);
        run(32'h40302010, 0, 1'b0, res, lat);
        check("stat_frames", bus.stat_frames, 3);
        check("stat_stall", bus.stat_stall, 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
